// File: rtl/counter_bcd_timer.sv
// BCD stopwatch/timer (MM:SS:hundredths) with prescaler, preset load and
// optional lap-hold display freeze, enabled by macro COUNTER_LAP_HOLD_EN.
module counter_bcd_timer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic [7:0] load_ms10,
  input  logic       lap,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic       done_o,
  output logic       wrap_o,
  output logic       load_err_o,
  output logic       lap_o
);

  localparam logic [15:0] PRESC_TC = 16'(TICK_DIV - 1);
  localparam logic [7:0]  MAX_BCD  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  logic [15:0] presc, upd_presc;
  logic [7:0]  cnt_min, cnt_sec, cnt_ms;
  logic [7:0]  upd_min, upd_sec, upd_ms;
  logic        upd_done, upd_wrap, upd_err;
  logic        tick, load_ok, cnt_zero;

  function automatic logic [7:0] bcd_inc(input logic [7:0] x);
    if (x[3:0] == 4'd9) return {x[7:4] + 4'd1, 4'd0};
    else                return {x[7:4], x[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] x);
    if (x[3:0] == 4'd0) return {x[7:4] - 4'd1, 4'd9};
    else                return {x[7:4], x[3:0] - 4'd1};
  endfunction

  assign tick     = en && (presc == PRESC_TC);
  assign cnt_zero = (cnt_min == 8'h00) && (cnt_sec == 8'h00) && (cnt_ms == 8'h00);
  // With every digit valid BCD, a packed-BCD compare orders like the integer value.
  assign load_ok  = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                    (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                    (load_ms10[7:4] <= 4'd9) && (load_ms10[3:0] <= 4'd9) &&
                    (load_min <= MAX_BCD);

  always_comb begin
    upd_min   = cnt_min;
    upd_sec   = cnt_sec;
    upd_ms    = cnt_ms;
    upd_presc = presc;
    upd_done  = 1'b0;
    upd_wrap  = 1'b0;
    upd_err   = 1'b0;
    if (load) begin
      if (load_ok) begin
        upd_min   = load_min;
        upd_sec   = load_sec;
        upd_ms    = load_ms10;
        upd_presc = 16'd0;
      end else begin
        upd_err = 1'b1;
      end
    end else if (en) begin
      upd_presc = tick ? 16'd0 : presc + 16'd1;
      if (tick && !dir) begin
        if (cnt_ms != 8'h99) upd_ms = bcd_inc(cnt_ms);
        else begin
          upd_ms = 8'h00;
          if (cnt_sec != 8'h59) upd_sec = bcd_inc(cnt_sec);
          else begin
            upd_sec = 8'h00;
            if (cnt_min != MAX_BCD) upd_min = bcd_inc(cnt_min);
            else begin
              upd_min  = 8'h00;
              upd_wrap = 1'b1;
            end
          end
        end
      end else if (tick && !cnt_zero) begin
        if (cnt_ms != 8'h00) upd_ms = bcd_dec(cnt_ms);
        else begin
          upd_ms = 8'h99;
          if (cnt_sec != 8'h00) upd_sec = bcd_dec(cnt_sec);
          else begin
            upd_sec = 8'h59;
            upd_min = bcd_dec(cnt_min);
          end
        end
        upd_done = (upd_min == 8'h00) && (upd_sec == 8'h00) && (upd_ms == 8'h00);
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      presc      <= 16'd0;
      cnt_min    <= 8'h00;
      cnt_sec    <= 8'h00;
      cnt_ms     <= 8'h00;
      done_o     <= 1'b0;
      wrap_o     <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      presc      <= upd_presc;
      cnt_min    <= upd_min;
      cnt_sec    <= upd_sec;
      cnt_ms     <= upd_ms;
      done_o     <= upd_done;
      wrap_o     <= upd_wrap;
      load_err_o <= upd_err;
    end
  end

`ifdef COUNTER_LAP_HOLD_EN
  logic       hold_on;
  logic [7:0] hold_min, hold_sec, hold_ms;

  // The frozen value is the count as it stands after the entering edge.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      hold_on  <= 1'b0;
      hold_min <= 8'h00;
      hold_sec <= 8'h00;
      hold_ms  <= 8'h00;
    end else if (lap) begin
      hold_on <= !hold_on;
      if (!hold_on) begin
        hold_min <= upd_min;
        hold_sec <= upd_sec;
        hold_ms  <= upd_ms;
      end
    end
  end

  assign min_o   = hold_on ? hold_min : cnt_min;
  assign sec_o   = hold_on ? hold_sec : cnt_sec;
  assign ms_10_o = hold_on ? hold_ms  : cnt_ms;
  assign lap_o   = hold_on;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign min_o      = cnt_min;
  assign sec_o      = cnt_sec;
  assign ms_10_o    = cnt_ms;
  assign lap_o      = 1'b0;
`endif

endmodule

// File: doc/counter_bcd_timer.md
COUNTER_BCD_TIMER -- requirements
Module: counter_bcd_timer

Interface
REQ-001 Parameter TICK_DIV, default 1, SHALL set the number of enabled clk_core cycles per 10 ms count step (range 1..65535).
REQ-002 Parameter MAX_MIN, default 59, SHALL set the highest minute value as an integer in the range 1..99.
REQ-003 Port clk_core, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port en, input, 1 bit, SHALL be the run enable; the count and prescaler advance only while it is high.
REQ-006 Port dir, input, 1 bit, SHALL select the count direction: 0 = count up, 1 = count down.
REQ-007 Port load, input, 1 bit, SHALL be a one-cycle request to preset the count.
REQ-008 Ports load_min, load_sec and load_ms10, inputs, 8 bits each, SHALL carry the packed-BCD preset value.
REQ-009 Port lap, input, 1 bit, SHALL be a one-cycle toggle request for the lap hold.
REQ-010 Ports min_o, sec_o and ms_10_o, outputs, 8 bits each, SHALL carry the packed-BCD display value (high nibble = tens digit).
REQ-011 Port done_o, output, 1 bit, SHALL be a one-cycle pulse when a down-count reaches zero.
REQ-012 Port wrap_o, output, 1 bit, SHALL be a one-cycle pulse when an up-count rolls over.
REQ-013 Port load_err_o, output, 1 bit, SHALL be a one-cycle pulse when a load is rejected.
REQ-014 Port lap_o, output, 1 bit, SHALL be high while the display is frozen.

Function
REQ-015 Prescaler SHALL increment on each clk_core cycle with en=1; on reaching TICK_DIV-1 it SHALL return to 0 and issue one internal tick; with en=0 it SHALL hold.
REQ-016 Count ranges SHALL be: ms_10 00..99, sec 00..59, min 00..MAX_MIN, every digit valid BCD; a tick SHALL change the count on the same clock edge (no extra output lag).
REQ-017 Up tick: ms_10 increments; 99->00 carries into sec; 59->00 carries into min; at MAX_MIN:59:99 the count SHALL go to 00:00:00 with wrap_o=1 for one cycle.
REQ-018 Down tick: ms_10 decrements with borrow through sec and min; the tick that produces 00:00:00 SHALL assert done_o for one cycle.
REQ-019 Down ticks at 00:00:00 SHALL leave the count at zero and SHALL NOT assert done_o again.
REQ-020 A dir change SHALL take effect on the next tick; it SHALL NOT alter the current count or prescaler.
REQ-021 load=1 SHALL take priority over a tick in the same cycle; a valid preset SHALL be applied on that edge, clear the prescaler, and suppress done_o and wrap_o for that cycle.
REQ-022 A preset SHALL be valid only if every digit is <=9, the sec tens digit is <=5, and min <= MAX_MIN.
REQ-023 A load regardless of en SHALL be honoured: a valid preset is applied; an invalid one leaves count and prescaler unchanged and pulses load_err_o for one cycle.
REQ-024 When lap hold is released, the outputs SHALL equal the live count.

Reset
REQ-025 rst=1 SHALL override en, load and lap, and on that edge set the count to 00:00:00, the prescaler to 0, all outputs to 0, and release the lap hold.
REQ-026 Asserting rst mid-count or mid-lap SHALL give the same result as REQ-025, with no residual pulse in the following cycle.

Configuration
REQ-027 With macro COUNTER_LAP_HOLD_EN defined, lap=1 SHALL toggle the hold: when entering, the outputs freeze at the live count and lap_o=1; when leaving, the outputs track the live count again and lap_o=0.
REQ-028 With COUNTER_LAP_HOLD_EN defined, the internal count SHALL keep running during the hold; a load during the hold SHALL update the internal count only; done_o and wrap_o SHALL remain live.
REQ-029 Without COUNTER_LAP_HOLD_EN, lap SHALL be ignored, lap_o SHALL be tied to 0, and no hold registers SHALL be synthesised.

Verification
REQ-030 TICK_DIV=1, dir=0, en=1 from reset for 6000 cycles -> outputs 01:00:00; no wrap_o.
REQ-031 MAX_MIN=59, load 59:59:98, then 2 up ticks -> 59:59:99, then 00:00:00 with wrap_o high for exactly 1 cycle.
REQ-032 dir=1, load 00:00:02, then 3 ticks -> 00:00:01, 00:00:00 with done_o pulsed once, then holds 00:00:00 with no second pulse.
REQ-033 Load 00:60:00 or 00:0A:00 -> count unchanged and load_err_o pulsed; load asserted together with a tick -> preset applied exactly, not preset+1.
REQ-034 TICK_DIV=4, en toggling 1,1,0,0,1,1 -> exactly one tick, after the sixth cycle.
REQ-035 COUNTER_LAP_HOLD_EN defined: lap at 00:00:10, run 50 cycles -> outputs stay 00:00:10; second lap -> outputs 00:00:60; rst during hold -> all zero and lap_o=0.
